// File: rtl/ram16k_seq_engine_pkg.sv
// ram16k_seq_engine_pkg
// Shared definitions for the 16K x 16 RAM sequencing engine: FSM state
// encoding, command opcodes and default geometry of the target RAM.
package ram16k_seq_engine_pkg;

    localparam int AW_DEF  = 14;
    localparam int DW_DEF  = 16;
    localparam int MAX_LEN = 16384;

    localparam logic OP_FILL   = 1'b0;
    localparam logic OP_VERIFY = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/ram16k_rd_pipe.sv
// ram16k_rd_pipe
// RD_LAT-deep shift register that carries {valid, expected, addr} for each
// issued read so the tag lines up with the RAM's DOut when it returns.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset (valid tags only)
//   vld_i/exp_i/addr_i tag entering the pipe on the cycle the read is issued
//   vld_o/exp_o/addr_o tag aligned with the returning read data
module ram16k_rd_pipe
    import ram16k_seq_engine_pkg::*;
#(
    parameter int RD_LAT = 1,
    parameter int AW     = AW_DEF,
    parameter int DW     = DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          vld_i,
    input  logic [DW-1:0] exp_i,
    input  logic [AW-1:0] addr_i,
    output logic          vld_o,
    output logic [DW-1:0] exp_o,
    output logic [AW-1:0] addr_o
);

    logic [RD_LAT-1:0] vld_q;
    logic [DW-1:0]     exp_q  [RD_LAT];
    logic [AW-1:0]     addr_q [RD_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= vld_i;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    // Payload is qualified by vld_q, so it needs no reset.
    always_ff @(posedge clk) begin
        exp_q[0]  <= exp_i;
        addr_q[0] <= addr_i;
        for (int i = 1; i < RD_LAT; i++) begin
            exp_q[i]  <= exp_q[i-1];
            addr_q[i] <= addr_q[i-1];
        end
    end

    assign vld_o  = vld_q[RD_LAT-1];
    assign exp_o  = exp_q[RD_LAT-1];
    assign addr_o = addr_q[RD_LAT-1];

endmodule

// File: rtl/ram16k_seq_engine.sv
// ram16k_seq_engine
// Self-timed fill/verify initiator for a 16K x 16 synchronous RAM. A fill
// writes seed+i to base+i for i in 0..len-1; a verify reads the same range
// back and counts words that differ from seed+i, remembering the first one.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   start, op, base, len, seed command (sampled only in IDLE)
//   busy, done               status; done is a one-cycle completion pulse
//   err_cnt, err_addr        verify mismatch count (saturating), first bad address
//   ram_e/ram_w/ram_r/ram_addr/ram_din  registered RAM command outputs
//   ram_dout                 RAM read data, RD_LAT cycles after ram_r
module ram16k_seq_engine
    import ram16k_seq_engine_pkg::*;
#(
    parameter int RD_LAT = 1,
    parameter int AW     = AW_DEF,
    parameter int DW     = DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          op,
    input  logic [AW-1:0] base,
    input  logic [AW:0]   len,
    input  logic [DW-1:0] seed,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] err_cnt,
    output logic [AW-1:0] err_addr,
    output logic          ram_e,
    output logic          ram_w,
    output logic          ram_r,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    function automatic logic [DW-1:0] sat_inc(input logic [DW-1:0] v);
        return (&v) ? v : v + DW'(1);
    endfunction

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] pat_q, pat_d;
    logic [AW:0]   rem_q, rem_d;      // words still to issue, including the current one
    logic [2:0]    drain_q, drain_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          e_q, e_d;
    logic          w_q, w_d;
    logic          r_q, r_d;
    logic [DW-1:0] err_cnt_q, err_cnt_d;
    logic [AW-1:0] err_addr_q, err_addr_d;

    logic          pv;
    logic [DW-1:0] pexp;
    logic [AW-1:0] paddr;

    // The tag enters the pipe on the same edge the RAM samples the read.
    ram16k_rd_pipe #(
        .RD_LAT (RD_LAT),
        .AW     (AW),
        .DW     (DW)
    ) u_rd_pipe (
        .clk    (clk),
        .rst_n  (rst_n),
        .vld_i  (r_q),
        .exp_i  (pat_q),
        .addr_i (addr_q),
        .vld_o  (pv),
        .exp_o  (pexp),
        .addr_o (paddr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            pat_q      <= '0;
            rem_q      <= '0;
            drain_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            e_q        <= 1'b0;
            w_q        <= 1'b0;
            r_q        <= 1'b0;
            err_cnt_q  <= '0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            pat_q      <= pat_d;
            rem_q      <= rem_d;
            drain_q    <= drain_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            e_q        <= e_d;
            w_q        <= w_d;
            r_q        <= r_d;
            err_cnt_q  <= err_cnt_d;
            err_addr_q <= err_addr_d;
        end
    end

    // Outputs are registered, so every next-state value below describes
    // what the RAM and host see in the following cycle.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        pat_d      = pat_q;
        rem_d      = rem_q;
        drain_d    = drain_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        e_d        = e_q;
        w_d        = w_q;
        r_d        = r_q;
        err_cnt_d  = err_cnt_q;
        err_addr_d = err_addr_q;

        if (pv && (ram_dout != pexp)) begin
            err_cnt_d = sat_inc(err_cnt_q);
            if (err_cnt_q == '0) begin
                err_addr_d = paddr;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    err_cnt_d  = '0;
                    err_addr_d = '0;
                    if (len == '0) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        addr_d = base;
                        pat_d  = seed;
                        rem_d  = len;
                        busy_d = 1'b1;
                        e_d    = 1'b1;
                        if (op == OP_FILL) begin
                            w_d     = 1'b1;
                            state_d = ST_WRITE;
                        end else begin
                            r_d     = 1'b1;
                            state_d = ST_READ;
                        end
                    end
                end
            end

            ST_WRITE: begin
                if (rem_q == (AW+1)'(1)) begin
                    e_d     = 1'b0;
                    w_d     = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    addr_d = addr_q + AW'(1);   // wraps 16383 -> 0
                    pat_d  = pat_q + DW'(1);
                    rem_d  = rem_q - (AW+1)'(1);
                end
            end

            ST_READ: begin
                if (rem_q == (AW+1)'(1)) begin
                    e_d     = 1'b0;
                    r_d     = 1'b0;
                    drain_d = '0;
                    state_d = ST_DRAIN;
                end else begin
                    addr_d = addr_q + AW'(1);
                    pat_d  = pat_q + DW'(1);
                    rem_d  = rem_q - (AW+1)'(1);
                end
            end

            // Wait for the last RD_LAT returns to be compared.
            ST_DRAIN: begin
                if (drain_q == 3'(RD_LAT - 1)) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    drain_d = drain_q + 3'd1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign err_cnt  = err_cnt_q;
    assign err_addr = err_addr_q;
    assign ram_e    = e_q;
    assign ram_w    = w_q;
    assign ram_r    = r_q;
    assign ram_addr = addr_q;
    assign ram_din  = pat_q;

endmodule
